// File: rtl/obj_spawn_scheduler_if.sv
// Note-event / spawn handshake bundle between the MIDI front end, the
// spawn scheduler and the game logic object slots.
interface obj_spawn_scheduler_if;
   logic        note_valid;
   logic [4:0]  note_id;
   logic        vsync_pulse;
   logic [4:0]  slot_busy;
   logic        spawn_valid;
   logic [2:0]  spawn_slot;
   logic [25:0] spawn_obj;
   logic        spawn_ack;
   logic [2:0]  pending;
   logic [7:0]  drop_count;

   modport master (
      output note_valid, note_id, vsync_pulse, slot_busy, spawn_ack,
      input  spawn_valid, spawn_slot, spawn_obj, pending, drop_count
   );

   modport slave (
      input  note_valid, note_id, vsync_pulse, slot_busy, spawn_ack,
      output spawn_valid, spawn_slot, spawn_obj, pending, drop_count
   );
endinterface

// File: rtl/obj_spawn_scheduler.sv
// Queues note events and issues frame-aligned, rate-limited object spawns
// into the first free game slot, scanning round-robin.
module obj_spawn_scheduler #(
   parameter int unsigned SCREEN_WIDTH = 1024,
   parameter int unsigned V_BASE       = 100,
   parameter int unsigned V_STEP       = 12,
   parameter int unsigned V_MAX        = 460,
   parameter int unsigned MIN_GAP      = 8
) (
   input logic                  clock,
   input logic                  reset_n,
   obj_spawn_scheduler_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SELECT, ISSUE} state_e;

   localparam logic [31:0] SW32     = SCREEN_WIDTH;
   localparam logic [10:0] HPOS     = SW32[10:0];
   localparam logic [10:0] V_BASE_W = 11'(V_BASE);
   localparam logic [10:0] V_STEP_W = 11'(V_STEP);
   localparam logic [10:0] V_MAX_W  = 11'(V_MAX);
   localparam logic [3:0]  GAP_W    = 4'(MIN_GAP);

   state_e      state_q, state_d;
   logic [4:0]  fifo_q [4];
   logic [1:0]  wptr_q, rptr_q;
   logic [2:0]  count_q, count_d;
   logic [3:0]  gap_q, gap_d;
   logic [2:0]  rr_q, rr_d;
   logic [7:0]  drop_q, drop_d;
   logic [2:0]  slot_q, slot_d;
   logic [25:0] obj_q, obj_d;
   logic        push_ok, pop;
   logic        free_found;
   logic [2:0]  free_slot;
   logic [3:0]  idx;
   logic [4:0]  head;
   logic [10:0] vsum, vpos;
   logic [25:0] word;

   assign head = fifo_q[rptr_q];
   assign vsum = V_BASE_W + 11'(head) * V_STEP_W;
   assign vpos = (vsum > V_MAX_W) ? V_MAX_W : vsum;
   assign word = {3'b000, head[4:3], HPOS, vpos[9:0]};

   always_comb begin
      free_found = 1'b0;
      free_slot  = '0;
      idx        = '0;
      for (int unsigned k = 0; k < 5; k++) begin
         idx = {1'b0, rr_q} + 4'(k);
         if (idx >= 4'd5) idx = idx - 4'd5;
         if (!free_found && !bus.slot_busy[idx[2:0]]) begin
            free_found = 1'b1;
            free_slot  = idx[2:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      obj_d   = obj_q;
      rr_d    = rr_q;
      gap_d   = gap_q;
      pop     = 1'b0;
      if (bus.vsync_pulse && gap_q != '0) gap_d = gap_q - 4'd1;
      case (state_q)
         // gap_q==1 means this very pulse exhausts the gap, so it may spawn
         IDLE: if (bus.vsync_pulse && count_q != '0 && gap_q <= 4'd1) state_d = SELECT;
         SELECT: begin
            if (free_found) begin
               slot_d  = free_slot;
               obj_d   = word;
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (bus.spawn_ack) begin
               pop     = 1'b1;
               rr_d    = (slot_q == 3'd4) ? 3'd0 : slot_q + 3'd1;
               gap_d   = GAP_W;
               state_d = IDLE;
            end else if (bus.slot_busy[slot_q]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      push_ok = bus.note_valid && (count_q != 3'd4 || pop);
      count_d = count_q + {2'b00, push_ok} - {2'b00, pop};
      drop_d  = drop_q;
      if (bus.note_valid && !push_ok && drop_q != '1) drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         gap_q   <= '0;
         rr_q    <= '0;
         drop_q  <= '0;
         slot_q  <= '0;
         obj_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         gap_q   <= gap_d;
         rr_q    <= rr_d;
         drop_q  <= drop_d;
         slot_q  <= slot_d;
         obj_q   <= obj_d;
         if (push_ok) wptr_q <= wptr_q + 2'd1;
         if (pop)     rptr_q <= rptr_q + 2'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) fifo_q[wptr_q] <= bus.note_id;
   end

   assign bus.spawn_valid = (state_q == ISSUE);
   assign bus.spawn_slot  = slot_q;
   assign bus.spawn_obj   = obj_q;
   assign bus.pending     = count_q;
   assign bus.drop_count  = drop_q;

endmodule

// File: tb/tb_obj_spawn_scheduler.sv
// Directed bench: a default-parameter scheduler plus a V_STEP=20 copy fed the
// same stimulus so vertical clamping is exercised alongside normal builds.
module tb_obj_spawn_scheduler;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   obj_spawn_scheduler_if if1 ();
   obj_spawn_scheduler_if if2 ();

   assign if2.note_valid  = if1.note_valid;
   assign if2.note_id     = if1.note_id;
   assign if2.vsync_pulse = if1.vsync_pulse;
   assign if2.slot_busy   = if1.slot_busy;
   assign if2.spawn_ack   = if1.spawn_ack;

   obj_spawn_scheduler u_dut (
      .clock   (clk),
      .reset_n (reset_n),
      .bus     (if1.slave)
   );

   obj_spawn_scheduler #(.V_STEP(20)) u_clamp (
      .clock   (clk),
      .reset_n (reset_n),
      .bus     (if2.slave)
   );

   typedef struct {
      logic [4:0] id;
      logic [4:0] busy;
      logic       exp_valid;
      logic [2:0] exp_slot;
      logic [1:0] exp_ident;
      logic [9:0] exp_v1;
      logic [9:0] exp_v2;
   } vec_t;

   vec_t vecs[9];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n            = 1'b0;
      if1.note_valid     = 1'b0;
      if1.note_id        = '0;
      if1.vsync_pulse    = 1'b0;
      if1.slot_busy      = '0;
      if1.spawn_ack      = 1'b0;
      cyc();
      cyc();
      reset_n = 1'b1;
   endtask

   task automatic push_note(input logic [4:0] id);
      if1.note_valid = 1'b1;
      if1.note_id    = id;
      cyc();
      if1.note_valid = 1'b0;
   endtask

   task automatic vsync();
      if1.vsync_pulse = 1'b1;
      cyc();
      if1.vsync_pulse = 1'b0;
   endtask

   task automatic ack();
      if1.spawn_ack = 1'b1;
      cyc();
      if1.spawn_ack = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      //        id     busy       v  slot ident v1    v2
      vecs[0] = '{5'd24, 5'b00000, 1, 3'd0, 2'd3, 10'd388, 10'd460};
      vecs[1] = '{5'd0,  5'b00001, 1, 3'd1, 2'd0, 10'd100, 10'd100};
      vecs[2] = '{5'd5,  5'b01111, 1, 3'd4, 2'd0, 10'd160, 10'd200};
      vecs[3] = '{5'd10, 5'b00111, 1, 3'd3, 2'd1, 10'd220, 10'd300};
      vecs[4] = '{5'd17, 5'b11111, 0, 3'd0, 2'd2, 10'd304, 10'd440};
      vecs[5] = '{5'd1,  5'b11101, 1, 3'd1, 2'd0, 10'd112, 10'd120};
      vecs[6] = '{5'd12, 5'b10110, 1, 3'd0, 2'd1, 10'd244, 10'd340};
      vecs[7] = '{5'd18, 5'b00000, 1, 3'd0, 2'd2, 10'd316, 10'd460};
      vecs[8] = '{5'd19, 5'b00000, 1, 3'd0, 2'd2, 10'd328, 10'd460};

      // Reset state
      do_reset();
      chk("rst_valid", 32'(if1.spawn_valid), 0);
      chk("rst_slot",  32'(if1.spawn_slot), 0);
      chk("rst_obj",   32'(if1.spawn_obj), 0);
      chk("rst_pending", 32'(if1.pending), 0);
      chk("rst_drop",  32'(if1.drop_count), 0);

      // Table: word build, clamp and slot scan from rr=0
      for (int i = 0; i < 9; i++) begin
         do_reset();
         if1.slot_busy = vecs[i].busy;
         push_note(vecs[i].id);
         chk("vec_pending_push", 32'(if1.pending), 1);
         vsync();
         chk("vec_select_no_valid", 32'(if1.spawn_valid), 0);
         cyc();
         chk("vec_valid",  32'(if1.spawn_valid), 32'(vecs[i].exp_valid));
         chk("vec_valid2", 32'(if2.spawn_valid), 32'(vecs[i].exp_valid));
         if (vecs[i].exp_valid) begin
            chk("vec_slot", 32'(if1.spawn_slot), 32'(vecs[i].exp_slot));
            chk("vec_obj",  32'(if1.spawn_obj),
                32'({3'b000, vecs[i].exp_ident, 11'd1024, vecs[i].exp_v1}));
            chk("vec_obj_clamp", 32'(if2.spawn_obj),
                32'({3'b000, vecs[i].exp_ident, 11'd1024, vecs[i].exp_v2}));
            ack();
            chk("vec_ack_valid",   32'(if1.spawn_valid), 0);
            chk("vec_ack_pending", 32'(if1.pending), 0);
         end else begin
            chk("vec_nofree_pending", 32'(if1.pending), 1);
         end
      end

      // Gap enforcement and round-robin advance
      do_reset();
      push_note(5'd3);
      push_note(5'd4);
      vsync();
      cyc();
      chk("gap_first_valid", 32'(if1.spawn_valid), 1);
      chk("gap_first_slot",  32'(if1.spawn_slot), 0);
      cyc();
      chk("issue_hold_valid", 32'(if1.spawn_valid), 1);
      chk("issue_hold_obj", 32'(if1.spawn_obj), 32'({3'b000, 2'd0, 11'd1024, 10'd136}));
      ack();
      chk("gap_ack_pending", 32'(if1.pending), 1);
      for (int p = 1; p <= 7; p++) begin
         vsync();
         cyc();
         chk("gap_hold", 32'(if1.spawn_valid), 0);
      end
      vsync();
      cyc();
      chk("gap_8th_valid", 32'(if1.spawn_valid), 1);
      chk("gap_8th_slot",  32'(if1.spawn_slot), 1);
      chk("gap_8th_obj", 32'(if1.spawn_obj), 32'({3'b000, 2'd0, 11'd1024, 10'd148}));
      ack();
      chk("gap_done_pending", 32'(if1.pending), 0);

      // All slots busy, then one frees; ack beats a simultaneous busy
      do_reset();
      if1.slot_busy = 5'b11111;
      push_note(5'd9);
      vsync();
      cyc();
      chk("full_slots_valid",   32'(if1.spawn_valid), 0);
      chk("full_slots_pending", 32'(if1.pending), 1);
      if1.slot_busy = 5'b11011;
      vsync();
      cyc();
      chk("freed_valid", 32'(if1.spawn_valid), 1);
      chk("freed_slot",  32'(if1.spawn_slot), 2);
      if1.slot_busy = 5'b11111;
      ack();
      chk("ack_wins_valid",   32'(if1.spawn_valid), 0);
      chk("ack_wins_pending", 32'(if1.pending), 0);

      // Withdraw on busy, no gap reload, then reset mid-ISSUE
      do_reset();
      if1.slot_busy = 5'b00111;
      push_note(5'd7);
      push_note(5'd8);
      vsync();
      cyc();
      chk("wd_valid", 32'(if1.spawn_valid), 1);
      chk("wd_slot",  32'(if1.spawn_slot), 3);
      if1.slot_busy = 5'b01111;
      cyc();
      chk("wd_dropped_valid", 32'(if1.spawn_valid), 0);
      chk("wd_pending",       32'(if1.pending), 2);
      if1.slot_busy = 5'b00111;
      vsync();
      cyc();
      chk("wd_retry_valid", 32'(if1.spawn_valid), 1);
      chk("wd_retry_slot",  32'(if1.spawn_slot), 3);
      reset_n = 1'b0;
      cyc();
      chk("rst_issue_valid",   32'(if1.spawn_valid), 0);
      chk("rst_issue_pending", 32'(if1.pending), 0);
      reset_n = 1'b1;

      // FIFO overflow, ignored ack, push+pop while full, drop saturation
      do_reset();
      for (int k = 0; k < 6; k++) begin
         if1.note_valid = 1'b1;
         if1.note_id    = 5'(k);
         cyc();
      end
      if1.note_valid = 1'b0;
      chk("ovf_pending", 32'(if1.pending), 4);
      chk("ovf_drop",    32'(if1.drop_count), 2);
      ack();
      chk("idle_ack_ignored", 32'(if1.pending), 4);
      vsync();
      cyc();
      chk("ovf_spawn_obj", 32'(if1.spawn_obj), 32'({3'b000, 2'd0, 11'd1024, 10'd100}));
      if1.note_valid = 1'b1;
      if1.note_id    = 5'd20;
      if1.spawn_ack  = 1'b1;
      cyc();
      if1.spawn_ack  = 1'b0;
      if1.note_valid = 1'b0;
      chk("pushpop_pending", 32'(if1.pending), 4);
      chk("pushpop_drop",    32'(if1.drop_count), 2);
      if1.note_valid = 1'b1;
      for (int k = 0; k < 260; k++) cyc();
      if1.note_valid = 1'b0;
      chk("drop_saturate", 32'(if1.drop_count), 255);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
